// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle adder that sums two WIDTH-bit operands plus
// carry-in, CHUNK bits per clock, rippling the carry through a register.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   start    request; accepted on a rising edge only while busy=0
//   A, B     WIDTH-bit operands, captured on the accepting edge
//   Cin      carry-in, captured on the accepting edge
//   busy     high while slices are being computed
//   done     one-cycle pulse when Sum/Carry/Overflow have just updated
//   Sum      WIDTH-bit result, held until the next completion
//   Carry    unsigned carry-out of bit WIDTH-1
//   Overflow two's-complement overflow of the addition
module chunked_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               accept_c;
    logic               last_c;

    // Operands are shifted right one slice per cycle, so the active slice is
    // always the low CHUNK bits; the accumulator fills from the top.
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   acc;
    logic               carry_q;
    logic               a_msb;
    logic               b_msb;
    logic [IDX_W-1:0]   idx;

    logic [CHUNK:0]     slice_c;
    logic [WIDTH-1:0]   acc_next_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        last_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx == IDX_W'(N - 1)) begin
                    last_c     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One slice of the ripple: CHUNK-bit add with carry in and carry out
    always_comb begin
        slice_c    = (CHUNK + 1)'(a_sh[CHUNK-1:0])
                   + (CHUNK + 1)'(b_sh[CHUNK-1:0])
                   + (CHUNK + 1)'(carry_q);
        acc_next_c = (acc >> CHUNK)
                   | (WIDTH'(slice_c[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            carry_q  <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Sum      <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_c) begin
                a_sh    <= A;
                b_sh    <= B;
                carry_q <= Cin;
                a_msb   <= A[WIDTH-1];
                b_msb   <= B[WIDTH-1];
                acc     <= '0;
                idx     <= '0;
                busy    <= 1'b1;
            end else if (state == RUN) begin
                a_sh    <= a_sh >> CHUNK;
                b_sh    <= b_sh >> CHUNK;
                carry_q <= slice_c[CHUNK];
                acc     <= acc_next_c;
                idx     <= idx + IDX_W'(1);
                if (last_c) begin
                    Sum      <= acc_next_c;
                    Carry    <= slice_c[CHUNK];
                    Overflow <= (a_msb == b_msb) && (acc_next_c[WIDTH-1] != a_msb);
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
            end
        end
    end

endmodule
